// File: rtl/uns_6x3_div.sv
// uns_6x3_div: sequential unsigned restoring divider producing one quotient bit per clock.
// Optional macro UNS_DIV_EARLY_EXIT_EN: when A < B the COMPUTE phase is skipped and INIT finishes directly.
module uns_6x3_div #(
    parameter int DIVIDEND_WIDTH = 6,
    parameter int DIVISOR_WIDTH  = 3
) (
    input  logic                      SYS_CLOCK,
    input  logic                      FSM_ARESET,
    input  logic                      GO,
    input  logic [DIVIDEND_WIDTH-1:0] A,
    input  logic [DIVISOR_WIDTH-1:0]  B,
    output logic                      READY,
    output logic                      INIT,
    output logic                      COMPUTE,
    output logic                      RES,
    output logic [DIVIDEND_WIDTH-1:0] Q_REG,
    output logic [DIVISOR_WIDTH-1:0]  R_REG,
    output logic                      DIV_ZERO
);

    localparam int CW = $clog2(DIVIDEND_WIDTH + 1);
`ifdef UNS_DIV_EARLY_EXIT_EN
    localparam int MW = (DIVIDEND_WIDTH > DIVISOR_WIDTH) ? DIVIDEND_WIDTH : DIVISOR_WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_COMPUTE,
        ST_RES
    } state_t;

    state_t                    state_q, state_d;
    logic [DIVIDEND_WIDTH-1:0] aq_q, aq_d;
    logic [DIVISOR_WIDTH-1:0]  d_q, d_d;
    logic [DIVISOR_WIDTH-1:0]  p_q, p_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0] q_reg_q, q_reg_d;
    logic [DIVISOR_WIDTH-1:0]  r_reg_q, r_reg_d;
    logic                      div_zero_q, div_zero_d;

    // The partial remainder is always below D after a step, so its extra
    // top bit is only needed in the widened trial value, not in storage.
    logic [DIVISOR_WIDTH:0]    trial;
    logic                      fits;

    assign trial = {p_q, aq_q[DIVIDEND_WIDTH-1]};
    assign fits  = (trial >= {1'b0, d_q});

    assign READY    = (state_q == ST_IDLE);
    assign INIT     = (state_q == ST_INIT);
    assign COMPUTE  = (state_q == ST_COMPUTE);
    assign RES      = (state_q == ST_RES);
    assign Q_REG    = q_reg_q;
    assign R_REG    = r_reg_q;
    assign DIV_ZERO = div_zero_q;

    always_ff @(posedge SYS_CLOCK or posedge FSM_ARESET) begin
        if (FSM_ARESET) begin
            state_q    <= ST_IDLE;
            aq_q       <= '0;
            d_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            q_reg_q    <= '0;
            r_reg_q    <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            aq_q       <= aq_d;
            d_q        <= d_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            q_reg_q    <= q_reg_d;
            r_reg_q    <= r_reg_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        aq_d       = aq_q;
        d_d        = d_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        q_reg_d    = q_reg_q;
        r_reg_d    = r_reg_q;
        div_zero_d = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (GO) begin
                    aq_d    = A;
                    d_d     = B;
                    state_d = ST_INIT;
                end
            end

            ST_INIT: begin
                p_d   = '0;
                cnt_d = CW'(DIVIDEND_WIDTH);
                if (d_q == '0) begin
                    state_d    = ST_RES;
                    q_reg_d    = '1;
                    r_reg_d    = '0;
                    div_zero_d = 1'b1;
                end else begin
`ifdef UNS_DIV_EARLY_EXIT_EN
                    if (MW'(aq_q) < MW'(d_q)) begin
                        state_d    = ST_RES;
                        q_reg_d    = '0;
                        r_reg_d    = DIVISOR_WIDTH'(aq_q);
                        div_zero_d = 1'b0;
                    end else begin
                        state_d = ST_COMPUTE;
                    end
`else
                    state_d = ST_COMPUTE;
`endif
                end
            end

            ST_COMPUTE: begin
                p_d   = fits ? DIVISOR_WIDTH'(trial - {1'b0, d_q}) : DIVISOR_WIDTH'(trial);
                aq_d  = {aq_q[DIVIDEND_WIDTH-2:0], fits};
                cnt_d = cnt_q - CW'(1);
                // Last quotient bit: publish the finished quotient and remainder.
                if (cnt_q == CW'(1)) begin
                    state_d    = ST_RES;
                    q_reg_d    = {aq_q[DIVIDEND_WIDTH-2:0], fits};
                    r_reg_d    = p_d;
                    div_zero_d = 1'b0;
                end
            end

            ST_RES: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uns_6x3_div.sv
// tb_uns_6x3_div: randomized and directed checks of uns_6x3_div against a cycle-level arithmetic model.
// Honours UNS_DIV_EARLY_EXIT_EN when computing expected latencies.
module tb_uns_6x3_div;

    localparam int DW = 6;
    localparam int SW = 3;
    localparam int QMAX = (1 << DW) - 1;

    logic          SYS_CLOCK = 1'b0;
    logic          FSM_ARESET = 1'b1;
    logic          GO = 1'b0;
    logic [DW-1:0] A = '0;
    logic [SW-1:0] B = '0;
    logic          READY, INIT, COMPUTE, RES;
    logic [DW-1:0] Q_REG;
    logic [SW-1:0] R_REG;
    logic          DIV_ZERO;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    uns_6x3_div #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) dut (
        .SYS_CLOCK (SYS_CLOCK),
        .FSM_ARESET(FSM_ARESET),
        .GO        (GO),
        .A         (A),
        .B         (B),
        .READY     (READY),
        .INIT      (INIT),
        .COMPUTE   (COMPUTE),
        .RES       (RES),
        .Q_REG     (Q_REG),
        .R_REG     (R_REG),
        .DIV_ZERO  (DIV_ZERO)
    );

    always #5 SYS_CLOCK = ~SYS_CLOCK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Edges from the GO-sampling edge (counted as 1) to the edge entering RES.
    function automatic int latOf(input int a, input int b);
        if (b == 0) return 2;
`ifdef UNS_DIV_EARLY_EXIT_EN
        if (a < b) return 2;
`endif
        return DW + 2;
    endfunction

    // Model state: k counts edges since the GO-sampling edge; 0 means idle.
    int k = 0, mLat = 0;
    int mQ = 0, mR = 0, mDz = 0;
    int nQ = 0, nR = 0, nDz = 0;
    int capA = 0, capB = 1;

    always @(posedge SYS_CLOCK or posedge FSM_ARESET) begin
        if (FSM_ARESET) begin
            k   <= 0;
            mQ  <= 0;
            mR  <= 0;
            mDz <= 0;
        end else if (k == 0) begin
            if (GO) begin
                k    <= 1;
                mLat <= latOf(int'(A), int'(B));
                capA <= int'(A);
                capB <= int'(B);
                if (B == 0) begin
                    nQ  <= QMAX;
                    nR  <= 0;
                    nDz <= 1;
                end else begin
                    nQ  <= int'(A) / int'(B);
                    nR  <= int'(A) % int'(B);
                    nDz <= 0;
                end
            end
        end else if (k == mLat) begin
            k <= 0;
        end else begin
            k <= k + 1;
            if (k + 1 == mLat) begin
                mQ  <= nQ;
                mR  <= nR;
                mDz <= nDz;
            end
        end
    end

    function automatic int expStatus(input int kk, input int lat);
        if (kk == 0)   return 8;
        if (kk == lat) return 1;
        if (kk == 1)   return 4;
        return 2;
    endfunction

    always @(negedge SYS_CLOCK) begin
        if (checkEn) begin
            checkOutput("status", {28'd0, READY, INIT, COMPUTE, RES}, expStatus(k, mLat));
            checkOutput("q_reg", Q_REG, mQ);
            checkOutput("r_reg", R_REG, mR);
            checkOutput("div_zero", DIV_ZERO, mDz);
            if (RES === 1'b1 && DIV_ZERO === 1'b0) begin
                checkOutput("invariant_qbr", Q_REG * capB + R_REG, capA);
                checkOutput("invariant_r_lt_b", int'(R_REG) < capB, 1);
            end
        end
    end

    // Called at posedge+1 with the DUT idle; leaves at posedge+1 with the DUT idle again.
    task automatic applyStimulus(input int a, input int b, input int qExp, input int rExp,
                                 input int dzExp, input int latExp);
        int edges;
        int computeCycles;
        A  = DW'(a);
        B  = SW'(b);
        GO = 1'b1;
        @(posedge SYS_CLOCK);
        #1;
        GO = 1'b0;
        edges = 1;
        computeCycles = 0;
        while (RES !== 1'b1 && edges < 40) begin
            if (COMPUTE === 1'b1) computeCycles++;
            @(posedge SYS_CLOCK);
            #1;
            edges++;
        end
        checkOutput("latency", edges, latExp);
        checkOutput("compute_cycles", computeCycles, latExp - 2);
        checkOutput("op_q", Q_REG, qExp);
        checkOutput("op_r", R_REG, rExp);
        checkOutput("op_dz", DIV_ZERO, dzExp);
        @(posedge SYS_CLOCK);
        #1;
    endtask

    initial begin
        int resAt;
        int waitCnt;
        int ra, rb;

        FSM_ARESET = 1'b1;
        repeat (2) @(posedge SYS_CLOCK);
        #1;
        checkOutput("reset_ready", READY, 1);
        checkOutput("reset_busy", {INIT, COMPUTE, RES}, 0);
        checkOutput("reset_q", Q_REG, 0);
        checkOutput("reset_r", R_REG, 0);
        checkOutput("reset_dz", DIV_ZERO, 0);
        FSM_ARESET = 1'b0;
        checkEn = 1'b1;
        @(posedge SYS_CLOCK);
        #1;

        applyStimulus(45, 5, 9, 0, 0, 8);
        applyStimulus(50, 7, 7, 1, 0, 8);
        applyStimulus(63, 1, 63, 0, 0, 8);
        applyStimulus(63, 7, 9, 0, 0, 8);
        applyStimulus(5, 0, 63, 0, 1, 2);
        applyStimulus(6, 4, 1, 2, 0, 8);
`ifdef UNS_DIV_EARLY_EXIT_EN
        applyStimulus(2, 6, 0, 2, 0, 2);
`else
        applyStimulus(2, 6, 0, 2, 0, 8);
`endif

        // Asynchronous reset in the middle of the third COMPUTE cycle.
        A  = 6'd45;
        B  = 3'd5;
        GO = 1'b1;
        @(posedge SYS_CLOCK);
        #1;
        GO = 1'b0;
        repeat (3) @(posedge SYS_CLOCK);
        #3;
        checkOutput("pre_reset_compute", COMPUTE, 1);
        FSM_ARESET = 1'b1;
        #1;
        checkOutput("midreset_ready", READY, 1);
        checkOutput("midreset_busy", {INIT, COMPUTE, RES}, 0);
        checkOutput("midreset_q", Q_REG, 0);
        checkOutput("midreset_r", R_REG, 0);
        checkOutput("midreset_dz", DIV_ZERO, 0);
        @(posedge SYS_CLOCK);
        #3;
        FSM_ARESET = 1'b0;
        @(posedge SYS_CLOCK);
        #1;
        applyStimulus(10, 3, 3, 1, 0, 8);

        // GO held high with B toggling after capture: back-to-back operations.
        A  = 6'd20;
        B  = 3'd3;
        GO = 1'b1;
        @(posedge SYS_CLOCK);
        #1;
        resAt = -10;
        for (int i = 0; i < 24; i++) begin
            B = (i % 2 == 0) ? 3'd0 : 3'd3;
            @(posedge SYS_CLOCK);
            #1;
            if (RES === 1'b1 && resAt < 0) begin
                resAt = i;
                checkOutput("held_first_q", Q_REG, 6);
                checkOutput("held_first_r", R_REG, 2);
                checkOutput("held_first_dz", DIV_ZERO, 0);
            end
            if (i == resAt + 1) checkOutput("held_idle_after_res", READY, 1);
            if (i == resAt + 2) checkOutput("held_init_restart", INIT, 1);
        end
        checkOutput("held_res_seen", resAt >= 0, 1);
        GO = 1'b0;
        waitCnt = 0;
        while (READY !== 1'b1 && waitCnt < 30) begin
            @(posedge SYS_CLOCK);
            #1;
            waitCnt++;
        end
        checkOutput("drain_ready", READY, 1);
        @(posedge SYS_CLOCK);
        #1;

        // Full operand sweep followed by random pairs.
        for (int a = 0; a <= QMAX; a++) begin
            for (int b = 0; b < (1 << SW); b++) begin
                if (b == 0) applyStimulus(a, b, QMAX, 0, 1, latOf(a, b));
                else        applyStimulus(a, b, a / b, a % b, 0, latOf(a, b));
            end
        end
        for (int n = 0; n < 100; n++) begin
            ra = int'($urandom_range(0, QMAX));
            rb = int'($urandom_range(0, (1 << SW) - 1));
            if (rb == 0) applyStimulus(ra, rb, QMAX, 0, 1, latOf(ra, rb));
            else         applyStimulus(ra, rb, ra / rb, ra % rb, 0, latOf(ra, rb));
        end

        @(posedge SYS_CLOCK);
        #1;
        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
